hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage ARM pipeline (F/D/E/M/W).
- Consumes the decode-stage register indices, the decoder's RA1D_valid/RA2D_valid/WA3D_valid qualifiers and the RegW/MemtoReg controls.
- Keeps its own E/M/W shadow copies of register usage and generates forwarding selects, stalls and flushes.
- Sequences the pipeline on load-use hazards, R15 writes and branch-predictor mispredicts, and counts stall and flush cycles.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- RA1D  in  4  decode-stage source register 1 index
- RA2D  in  4  decode-stage source register 2 index
- WA3D  in  4  decode-stage destination register index
- RA1D_valid  in  1  RA1D is a real read
- RA2D_valid  in  1  RA2D is a real read
- WA3D_valid  in  1  WA3D is a real destination
- RegWD  in  1  decode-stage register write enable
- MemtoRegD  in  1  decode-stage instruction is a load (LDR)
- CondExE  in  1  condition check passes for the instruction in E
- MispredictE  in  1  branch in E resolved against its prediction
- ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  SrcB select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold F/D register
- FlushD  out  1  clear F/D register
- FlushE  out  1  clear D/E register (bubble)
- stall_cnt  out  CNT_W  cycles with StallD=1, saturating
- flush_cnt  out  CNT_W  cycles with MispredictE=1, saturating

Behaviour:
- Reset (async, reset_n=0):
  - All shadow stage state cleared: valid bits 0, RegW 0, MemtoReg 0, indices 0.
  - Counters cleared to 0.
  - With D valids low, every output is 0.
  - Reset asserted mid-stall or mid-flush discards all pending state immediately.
- Shadow stages, updated on each rising clk:
  - E stage loads RA1D/RA2D/WA3D, their valids, RegWD and MemtoRegD, unless FlushE=1. With FlushE=1 it loads a bubble: all valids, RegW and MemtoReg = 0.
  - M stage loads WA3E and MemtoRegE, with RegWM = RegWE & WA3E_valid & CondExE.
  - W stage loads WA3M and RegWW = RegWM.
  - E, M and W always advance; stalls hold only F and D.
- Forwarding (combinational from shadow state):
  - ForwardAE = 10 if RA1E_valid & RegWM & WA3M==RA1E & RA1E!=15.
  - Otherwise 01 if RA1E_valid & RegWW & WA3W==RA1E & RA1E!=15.
  - Otherwise 00.
  - M has priority over W. ForwardBE is identical using RA2E.
  - R15 is never forwarded.
- Load-use hazard:
  - LdrStall = MemtoRegE & RegWE & WA3E_valid & ((RA1D_valid & RA1D==WA3E) | (RA2D_valid & RA2D==WA3E)).
  - CondExE is ignored (conservative stall).
- R15 write pending:
  - PCWrPending = any of D, E or M has a valid write to register 15.
  - D term: RegWD & WA3D_valid & WA3D==15. The E and M terms use the shadow-stage equivalents.
- Outputs when MispredictE=0:
  - StallD = LdrStall.
  - StallF = LdrStall | PCWrPending.
  - FlushE = LdrStall.
  - FlushD = PCWrPending & ~LdrStall.
- Outputs when MispredictE=1 (overrides):
  - StallF = 0 and StallD = 0, so fetch redirects.
  - FlushD = 1 and FlushE = 1.
  - The branch itself proceeds to M.
- Latency:
  - A load-use stall lasts exactly 1 cycle; the load reaches M and is then forwarded via ResultW path 01 next cycle.
  - An R15 write holds fetch until the writer has left M (3 cycles from D).
- Counters:
  - stall_cnt increments when StallD=1 and saturates at all-ones.
  - flush_cnt increments when MispredictE=1 and saturates at all-ones.
  - Neither counter wraps.
- Simultaneous events:
  - A load-use and a mispredict in the same cycle resolves as the mispredict only; stall_cnt does not increment.
  - A register matching in both M and W selects 10.

Test Plan:
1. ADD R1 in E, then SUB reading R1 in E the next cycle: ForwardAE=10. One cycle later, a dependent op with W match only: ForwardAE=01.
2. LDR R2 in E with RA2D=2 and RA2D_valid=1: StallF=StallD=FlushE=1 for exactly 1 cycle; next cycle ForwardBE=01; stall_cnt=1.
3. Same as 2 but RA2D_valid=0 (immediate operand): no stall, all flags 0.
4. MOV PC (WA3D=15, RegWD=1, WA3D_valid=1): StallF=1 for 3 consecutive cycles, FlushD=1 each cycle, then StallF=0.
5. MispredictE=1 concurrent with an LdrStall condition: StallF=StallD=0, FlushD=FlushE=1, flush_cnt=1, stall_cnt unchanged.
6. CondExE=0 on the E writer of R3: next-cycle RA1E=3 gives ForwardAE=00. Also: force stall_cnt to all-ones and check it holds. Also: assert reset_n low mid-stall and check all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for a 5-stage ARM pipeline (F/D/E/M/W).
// Tracks register usage of the instructions in E, M and W and produces
// forwarding selects, stall and flush controls, plus event counters.
module hazard_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RA1D_valid,
    input  logic             RA2D_valid,
    input  logic             WA3D_valid,
    input  logic             RegWD,
    input  logic             MemtoRegD,
    input  logic             CondExE,
    input  logic             MispredictE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] PC_REG = 4'd15;

    // E-stage shadow
    logic [3:0] ra1e_q, ra1e_d;
    logic [3:0] ra2e_q, ra2e_d;
    logic [3:0] wa3e_q, wa3e_d;
    logic       ra1e_v_q, ra1e_v_d;
    logic       ra2e_v_q, ra2e_v_d;
    logic       wa3e_v_q, wa3e_v_d;
    logic       regwe_q, regwe_d;
    logic       memtorege_q, memtorege_d;

    // M-stage shadow (RegWM already folds in destination validity and condition)
    logic [3:0] wa3m_q, wa3m_d;
    logic       regwm_q, regwm_d;

    // W-stage shadow
    logic [3:0] wa3w_q, wa3w_d;
    logic       regww_q, regww_d;

    // Counters
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ldr_stall;
    logic pc_wr_pending;

    // Hazard detection: load-use against E, and pending R15 writes in D/E/M
    always_comb begin
        ldr_stall     = 1'b0;
        pc_wr_pending = 1'b0;
        ldr_stall = memtorege_q & regwe_q & wa3e_v_q &
                    ((RA1D_valid & (RA1D == wa3e_q)) |
                     (RA2D_valid & (RA2D == wa3e_q)));
        pc_wr_pending = (RegWD & WA3D_valid & (WA3D == PC_REG)) |
                        (regwe_q & wa3e_v_q & (wa3e_q == PC_REG)) |
                        (regwm_q & (wa3m_q == PC_REG));
    end

    // Stall/flush outputs; a mispredict overrides any stall so fetch redirects
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (MispredictE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallD = ldr_stall;
            StallF = ldr_stall | pc_wr_pending;
            FlushE = ldr_stall;
            FlushD = pc_wr_pending & ~ldr_stall;
        end
    end

    // Forwarding selects: M result beats W result, R15 never forwarded
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (ra1e_v_q && regwm_q && (wa3m_q == ra1e_q) && (ra1e_q != PC_REG))
            ForwardAE = 2'b10;
        else if (ra1e_v_q && regww_q && (wa3w_q == ra1e_q) && (ra1e_q != PC_REG))
            ForwardAE = 2'b01;
        if (ra2e_v_q && regwm_q && (wa3m_q == ra2e_q) && (ra2e_q != PC_REG))
            ForwardBE = 2'b10;
        else if (ra2e_v_q && regww_q && (wa3w_q == ra2e_q) && (ra2e_q != PC_REG))
            ForwardBE = 2'b01;
    end

    // Next-state for shadow stages and saturating counters
    always_comb begin
        ra1e_d      = RA1D;
        ra2e_d      = RA2D;
        wa3e_d      = WA3D;
        ra1e_v_d    = RA1D_valid;
        ra2e_v_d    = RA2D_valid;
        wa3e_v_d    = WA3D_valid;
        regwe_d     = RegWD;
        memtorege_d = MemtoRegD;
        if (FlushE) begin
            ra1e_v_d    = 1'b0;
            ra2e_v_d    = 1'b0;
            wa3e_v_d    = 1'b0;
            regwe_d     = 1'b0;
            memtorege_d = 1'b0;
        end
        wa3m_d  = wa3e_q;
        regwm_d = regwe_q & wa3e_v_q & CondExE;
        wa3w_d  = wa3m_q;
        regww_d = regwm_q;

        stall_cnt_d = stall_cnt_q;
        if (StallD && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (MispredictE && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Pipeline shadow registers and counters; E/M/W always advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ra1e_q      <= '0;
            ra2e_q      <= '0;
            wa3e_q      <= '0;
            ra1e_v_q    <= 1'b0;
            ra2e_v_q    <= 1'b0;
            wa3e_v_q    <= 1'b0;
            regwe_q     <= 1'b0;
            memtorege_q <= 1'b0;
            wa3m_q      <= '0;
            regwm_q     <= 1'b0;
            wa3w_q      <= '0;
            regww_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ra1e_q      <= ra1e_d;
            ra2e_q      <= ra2e_d;
            wa3e_q      <= wa3e_d;
            ra1e_v_q    <= ra1e_v_d;
            ra2e_v_q    <= ra2e_v_d;
            wa3e_v_q    <= wa3e_v_d;
            regwe_q     <= regwe_d;
            memtorege_q <= memtorege_d;
            wa3m_q      <= wa3m_d;
            regwm_q     <= regwm_d;
            wa3w_q      <= wa3w_d;
            regww_q     <= regww_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, R15 writes,
// mispredict override, condition gating, counter saturation, async reset.
module tb_hazard_controller;

    logic        clk;
    logic        reset_n;
    logic [3:0]  RA1D, RA2D, WA3D;
    logic        RA1D_valid, RA2D_valid, WA3D_valid;
    logic        RegWD, MemtoRegD, CondExE, MispredictE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [15:0] stall_cnt, flush_cnt;

    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic        s_StallF, s_StallD, s_FlushD, s_FlushE;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    logic [3:0]  flags;
    assign flags = {StallF, StallD, FlushD, FlushE};

    int unsigned chk;
    int unsigned pass;

    hazard_controller #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RA1D_valid(RA1D_valid), .RA2D_valid(RA2D_valid), .WA3D_valid(WA3D_valid),
        .RegWD(RegWD), .MemtoRegD(MemtoRegD), .CondExE(CondExE), .MispredictE(MispredictE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    hazard_controller #(.CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RA1D_valid(RA1D_valid), .RA2D_valid(RA2D_valid), .WA3D_valid(WA3D_valid),
        .RegWD(RegWD), .MemtoRegD(MemtoRegD), .CondExE(CondExE), .MispredictE(MispredictE),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_d(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                         input logic v1, input logic v2, input logic vw,
                         input logic regw, input logic mem);
        RA1D = ra1; RA2D = ra2; WA3D = wa3;
        RA1D_valid = v1; RA2D_valid = v2; WA3D_valid = vw;
        RegWD = regw; MemtoRegD = mem;
    endtask

    task automatic clear_d();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_d();
        MispredictE = 1'b0;
        CondExE = 1'b1;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_d();
        MispredictE = 1'b0;
        CondExE = 1'b1;
        #2;
        chk++; if (flags !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags); else pass++;
        chk++; if (ForwardAE !== 2'b00) $display("FAIL reset_fwdA got=%b exp=00", ForwardAE); else pass++;
        chk++; if (ForwardBE !== 2'b00) $display("FAIL reset_fwdB got=%b exp=00", ForwardBE); else pass++;
        chk++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); else pass++;
        chk++; if (flush_cnt !== 16'd0) $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); else pass++;
        tick();
        reset_n = 1'b1;
        tick();
        chk++; if (flags !== 4'b0000) $display("FAIL post_reset_flags got=%b exp=0000", flags); else pass++;
    endtask

    task automatic test_forward();
        do_reset();
        set_d(4'd2, 4'd3, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD R1,R2,R3
        tick();
        set_d(4'd1, 4'd6, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // SUB R4,R1,R6
        #1;
        chk++; if (flags !== 4'b0000) $display("FAIL fwd_noload_flags got=%b exp=0000", flags); else pass++;
        tick();
        chk++; if (ForwardAE !== 2'b10) $display("FAIL fwd_m_A got=%b exp=10", ForwardAE); else pass++;
        chk++; if (ForwardBE !== 2'b00) $display("FAIL fwd_m_B got=%b exp=00", ForwardBE); else pass++;
        set_d(4'd1, 4'd4, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // ORR R5,R1,R4
        tick();
        chk++; if (ForwardAE !== 2'b01) $display("FAIL fwd_w_A got=%b exp=01", ForwardAE); else pass++;
        chk++; if (ForwardBE !== 2'b10) $display("FAIL fwd_m_B2 got=%b exp=10", ForwardBE); else pass++;
        set_d(4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // MOV R7,#imm
        tick();
        set_d(4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // MOV R7,#imm
        tick();
        set_d(4'd7, 4'd7, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD R8,R7,R7
        tick();
        chk++; if (ForwardAE !== 2'b10) $display("FAIL fwd_prio_A got=%b exp=10", ForwardAE); else pass++;
        chk++; if (ForwardBE !== 2'b10) $display("FAIL fwd_prio_B got=%b exp=10", ForwardBE); else pass++;
        clear_d();
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);   // LDR R2,[R0]
        #1;
        chk++; if (flags !== 4'b0000) $display("FAIL ldr_pre_flags got=%b exp=0000", flags); else pass++;
        tick();
        set_d(4'd0, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD R3,R0,R2
        #1;
        chk++; if (flags !== 4'b1101) $display("FAIL ldr_stall_flags got=%b exp=1101", flags); else pass++;
        tick();
        chk++; if (flags !== 4'b0000) $display("FAIL ldr_after_flags got=%b exp=0000", flags); else pass++;
        chk++; if (stall_cnt !== 16'd1) $display("FAIL ldr_stall_cnt got=%0d exp=1", stall_cnt); else pass++;
        tick();
        chk++; if (ForwardBE !== 2'b01) $display("FAIL ldr_fwdB got=%b exp=01", ForwardBE); else pass++;
        chk++; if (ForwardAE !== 2'b00) $display("FAIL ldr_fwdA got=%b exp=00", ForwardAE); else pass++;
        clear_d();
    endtask

    task automatic test_immediate();
        do_reset();
        set_d(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);   // LDR R2,[R0]
        tick();
        set_d(4'd2, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // indices match, no real reads
        #1;
        chk++; if (flags !== 4'b0000) $display("FAIL imm_flags got=%b exp=0000", flags); else pass++;
        tick();
        chk++; if (stall_cnt !== 16'd0) $display("FAIL imm_stall_cnt got=%0d exp=0", stall_cnt); else pass++;
        clear_d();
    endtask

    task automatic test_r15();
        do_reset();
        set_d(4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  // WA3D invalid: not a PC write
        #1;
        chk++; if (flags !== 4'b0000) $display("FAIL r15_invalid_flags got=%b exp=0000", flags); else pass++;
        set_d(4'd0, 4'd1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // MOV PC,R1
        #1;
        chk++; if (flags !== 4'b1010) $display("FAIL r15_c0_flags got=%b exp=1010", flags); else pass++;
        tick();
        set_d(4'd15, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // reader of R15
        #1;
        chk++; if (flags !== 4'b1010) $display("FAIL r15_c1_flags got=%b exp=1010", flags); else pass++;
        tick();
        clear_d();
        #1;
        chk++; if (flags !== 4'b1010) $display("FAIL r15_c2_flags got=%b exp=1010", flags); else pass++;
        chk++; if (ForwardAE !== 2'b00) $display("FAIL r15_nofwd got=%b exp=00", ForwardAE); else pass++;
        tick();
        chk++; if (flags !== 4'b0000) $display("FAIL r15_c3_flags got=%b exp=0000", flags); else pass++;
    endtask

    task automatic test_mispredict();
        do_reset();
        set_d(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);   // LDR R2,[R0]
        tick();
        set_d(4'd0, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // dependent reader
        MispredictE = 1'b1;
        #1;
        chk++; if (flags !== 4'b0011) $display("FAIL mp_flags got=%b exp=0011", flags); else pass++;
        tick();
        MispredictE = 1'b0;
        clear_d();
        #1;
        chk++; if (flags !== 4'b0000) $display("FAIL mp_after_flags got=%b exp=0000", flags); else pass++;
        chk++; if (flush_cnt !== 16'd1) $display("FAIL mp_flush_cnt got=%0d exp=1", flush_cnt); else pass++;
        chk++; if (stall_cnt !== 16'd0) $display("FAIL mp_stall_cnt got=%0d exp=0", stall_cnt); else pass++;
    endtask

    task automatic test_condex();
        do_reset();
        set_d(4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // ADDNE R3 (fails)
        tick();
        CondExE = 1'b0;
        set_d(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);   // reader of R3
        tick();
        CondExE = 1'b1;
        clear_d();
        #1;
        chk++; if (ForwardAE !== 2'b00) $display("FAIL condex_fwdA got=%b exp=00", ForwardAE); else pass++;
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        MispredictE = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        MispredictE = 1'b0;
        #1;
        chk++; if (flush_cnt !== 16'd5) $display("FAIL sat_flush_main got=%0d exp=5", flush_cnt); else pass++;
        chk++; if (s_flush_cnt !== 2'd3) $display("FAIL sat_flush_narrow got=%0d exp=3", s_flush_cnt); else pass++;

        do_reset();
        for (int i = 0; i < 11; i++) begin
            set_d(4'd2, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);  // LDR R2,[R2]
            tick();
        end
        chk++; if (flags !== 4'b1101) $display("FAIL sat_stalling_flags got=%b exp=1101", flags); else pass++;
        chk++; if (stall_cnt !== 16'd5) $display("FAIL sat_stall_main got=%0d exp=5", stall_cnt); else pass++;
        chk++; if (s_stall_cnt !== 2'd3) $display("FAIL sat_stall_narrow got=%0d exp=3", s_stall_cnt); else pass++;

        #2;
        reset_n = 1'b0;
        #1;
        chk++; if (flags !== 4'b0000) $display("FAIL async_rst_flags got=%b exp=0000", flags); else pass++;
        chk++; if (stall_cnt !== 16'd0) $display("FAIL async_rst_stall_cnt got=%0d exp=0", stall_cnt); else pass++;
        chk++; if (s_stall_cnt !== 2'd0) $display("FAIL async_rst_narrow got=%0d exp=0", s_stall_cnt); else pass++;
        chk++; if ({ForwardAE, ForwardBE} !== 4'b0000) $display("FAIL async_rst_fwd got=%b exp=0000", {ForwardAE, ForwardBE}); else pass++;
        clear_d();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        chk = 0;
        pass = 0;
        reset_n = 1'b0;
        clear_d();
        CondExE = 1'b1;
        MispredictE = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_immediate();
        test_r15();
        test_mispredict();
        test_condex();
        test_saturation_and_reset();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
